// File: rtl/wordcell_array_ctrl_if.sv
// Request/response handshake and Wordcell array bus bundle for wordcell_array_ctrl.
// master = requester plus cell array side, slave = the controller.
interface wordcell_array_ctrl_if #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              cell_op;
  logic [WORDS-1:0]  cell_sel;
  logic [DATA_W-1:0] cell_in_bus;
  logic [DATA_W-1:0] cell_out_bus;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, cell_out_bus,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, cell_op, cell_sel, cell_in_bus
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, cell_out_bus,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, cell_op, cell_sel, cell_in_bus
  );
endinterface

// File: rtl/wordcell_array_ctrl.sv
// Sequences single read/write requests onto an array of Wordcell latches with
// setup/pulse/hold phasing so op and data never move while a select is high.
module wordcell_array_ctrl #(
  parameter int WORDS    = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8,
  parameter int WR_PULSE = 2,
  parameter int RD_WAIT  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  wordcell_array_ctrl_if.slave bus
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_WR  = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] CNT_RD  = CNT_W'(RD_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_HOLD   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_err_req;

  logic               r_req_ready, w_req_ready_nxt;
  logic               r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]  r_rsp_rdata, w_rsp_rdata_nxt;
  logic               r_rsp_err, w_rsp_err_nxt;
  logic               r_cell_op, w_cell_op_nxt;
  logic [WORDS-1:0]   r_cell_sel, w_cell_sel_nxt;
  logic [DATA_W-1:0]  r_cell_in_bus, w_cell_in_bus_nxt;

  logic               w_accept;
  logic               w_addr_bad;
  logic [WORDS-1:0]   w_onehot;
  logic [DATA_W-1:0]  w_data_phase;

  assign w_addr_bad   = ({1'b0, bus.req_addr} >= (ADDR_W+1)'(WORDS));
  assign w_accept     = bus.req_valid & r_req_ready & (r_state == S_IDLE);
  assign w_onehot     = {{(WORDS-1){1'b0}}, 1'b1} << r_addr;
  assign w_data_phase = r_we ? r_wdata : {DATA_W{1'b0}};

  // Outputs are registered from the current state, so the pins trail the state by one cycle.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_req_ready_nxt   = 1'b0;
    w_rsp_valid_nxt   = 1'b0;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_err_nxt     = 1'b0;
    w_cell_op_nxt     = 1'b0;
    w_cell_sel_nxt    = {WORDS{1'b0}};
    w_cell_in_bus_nxt = {DATA_W{1'b0}};
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_req_ready_nxt = 1'b0;
          w_state_nxt     = w_addr_bad ? S_RESP : S_SETUP;
        end else begin
          w_req_ready_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      S_SETUP: begin
        w_cell_op_nxt     = r_we;
        w_cell_in_bus_nxt = w_data_phase;
        w_cnt_nxt         = r_we ? CNT_WR : CNT_RD;
        w_state_nxt       = S_ACCESS;
      end
      S_ACCESS: begin
        w_cell_op_nxt     = r_we;
        w_cell_in_bus_nxt = w_data_phase;
        w_cell_sel_nxt    = w_onehot;
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_HOLD: begin
        // The select pin is still high during this cycle, so the read bus is valid here.
        w_cell_op_nxt     = r_we;
        w_cell_in_bus_nxt = w_data_phase;
        w_state_nxt       = S_RESP;
        if (!r_we) begin
          w_rsp_rdata_nxt = bus.cell_out_bus;
        end else begin
          w_rsp_rdata_nxt = r_rsp_rdata;
        end
      end
      S_RESP: begin
        w_rsp_valid_nxt = 1'b1;
        w_rsp_err_nxt   = r_err_req;
        w_req_ready_nxt = 1'b1;
        w_state_nxt     = S_IDLE;
        if (r_we || r_err_req) begin
          w_rsp_rdata_nxt = {DATA_W{1'b0}};
        end else begin
          w_rsp_rdata_nxt = r_rsp_rdata;
        end
      end
      default: begin
        w_req_ready_nxt = 1'b1;
        w_state_nxt     = S_IDLE;
      end
    endcase
  end

  // State, phase counter, latched request and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= {CNT_W{1'b0}};
      r_we          <= 1'b0;
      r_addr        <= {ADDR_W{1'b0}};
      r_wdata       <= {DATA_W{1'b0}};
      r_err_req     <= 1'b0;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= {DATA_W{1'b0}};
      r_rsp_err     <= 1'b0;
      r_cell_op     <= 1'b0;
      r_cell_sel    <= {WORDS{1'b0}};
      r_cell_in_bus <= {DATA_W{1'b0}};
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_req_ready   <= w_req_ready_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_cell_op     <= w_cell_op_nxt;
      r_cell_sel    <= w_cell_sel_nxt;
      r_cell_in_bus <= w_cell_in_bus_nxt;
      if (w_accept) begin
        r_we      <= bus.req_we;
        r_addr    <= bus.req_addr;
        r_wdata   <= bus.req_wdata;
        r_err_req <= w_addr_bad;
      end
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.cell_op     = r_cell_op;
  assign bus.cell_sel    = r_cell_sel;
  assign bus.cell_in_bus = r_cell_in_bus;

endmodule

// File: tb/tb_wordcell_array_ctrl.sv
// Directed bench for wordcell_array_ctrl with a behavioural array of eight Wordcells
// whose read buses are OR-combined.
module tb_wordcell_array_ctrl;

  logic clk;
  logic clk_en;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [7:0] mem [8] = '{default: 8'h00};
  logic [7:0] out_bus;
  logic [7:0] prev_sel;
  logic       prev_op;
  logic [7:0] prev_in;

  wordcell_array_ctrl_if #(.WORDS(8), .ADDR_W(4), .DATA_W(8)) bus ();

  wordcell_array_ctrl #(
    .WORDS(8), .ADDR_W(4), .DATA_W(8), .WR_PULSE(2), .RD_WAIT(2)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : 1'b0;

  // Wordcell array: a selected word latches in_bus while op is high, and drives out_bus.
  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (bus.cell_op && bus.cell_sel[k]) mem[k] <= bus.cell_in_bus;
    end
  end

  always_comb begin
    out_bus = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (bus.cell_sel[k]) out_bus = out_bus | mem[k];
    end
  end
  assign bus.cell_out_bus = out_bus;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Select stays one-hot and op/in_bus never move while a select is held.
  always @(negedge clk) begin
    if (!rst) begin
      check_vec("sel_onehot", 32'($onehot0(bus.cell_sel)), 32'd1);
      if (bus.cell_sel != 8'h00 && prev_sel != 8'h00) begin
        check_vec("op_stable", 32'(bus.cell_op), 32'(prev_op));
        check_vec("in_stable", 32'(bus.cell_in_bus), 32'(prev_in));
      end
      prev_sel = bus.cell_sel;
      prev_op  = bus.cell_op;
      prev_in  = bus.cell_in_bus;
    end else begin
      prev_sel = 8'h00;
    end
  end

  task automatic wait_ready();
    int waited;
    waited = 0;
    @(negedge clk);
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_vec("ready_wait", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic run_txn(input logic we, input logic [3:0] addr, input logic [7:0] wd,
                         input logic [7:0] exp_rd, input logic exp_err);
    logic [7:0] exp_sel;
    logic [7:0] exp_in;
    exp_sel = 8'h01 << addr;
    exp_in  = we ? wd : 8'h00;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check_vec("c0_ready", 32'(bus.req_ready), 32'd0);
    check_vec("c0_rsp",   32'(bus.rsp_valid), 32'd0);
    check_vec("c0_sel",   32'(bus.cell_sel),  32'd0);
    if (exp_err) begin
      @(negedge clk);
      check_vec("err_valid", 32'(bus.rsp_valid), 32'd1);
      check_vec("err_flag",  32'(bus.rsp_err),   32'd1);
      check_vec("err_rdata", 32'(bus.rsp_rdata), 32'd0);
      check_vec("err_sel",   32'(bus.cell_sel),  32'd0);
      check_vec("err_ready", 32'(bus.req_ready), 32'd1);
    end else begin
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        case (c)
          1: begin
            check_vec("setup_op",  32'(bus.cell_op),     32'(we));
            check_vec("setup_sel", 32'(bus.cell_sel),    32'd0);
            check_vec("setup_in",  32'(bus.cell_in_bus), 32'(exp_in));
            check_vec("setup_rsp", 32'(bus.rsp_valid),   32'd0);
          end
          2, 3: begin
            check_vec("acc_sel", 32'(bus.cell_sel),    32'(exp_sel));
            check_vec("acc_op",  32'(bus.cell_op),     32'(we));
            check_vec("acc_in",  32'(bus.cell_in_bus), 32'(exp_in));
            check_vec("acc_rsp", 32'(bus.rsp_valid),   32'd0);
          end
          4: begin
            check_vec("hold_sel", 32'(bus.cell_sel),    32'd0);
            check_vec("hold_op",  32'(bus.cell_op),     32'(we));
            check_vec("hold_in",  32'(bus.cell_in_bus), 32'(exp_in));
            check_vec("hold_rsp", 32'(bus.rsp_valid),   32'd0);
          end
          default: begin
            check_vec("rsp_valid", 32'(bus.rsp_valid),   32'd1);
            check_vec("rsp_err",   32'(bus.rsp_err),     32'd0);
            check_vec("rsp_rdata", 32'(bus.rsp_rdata),   32'(exp_rd));
            check_vec("rsp_op",    32'(bus.cell_op),     32'd0);
            check_vec("rsp_in",    32'(bus.cell_in_bus), 32'd0);
            check_vec("rsp_ready", 32'(bus.req_ready),   32'd1);
          end
        endcase
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_vec({tag, "_ready"}, 32'(bus.req_ready),   32'd1);
    check_vec({tag, "_rsp"},   32'(bus.rsp_valid),   32'd0);
    check_vec({tag, "_sel"},   32'(bus.cell_sel),    32'd0);
    check_vec({tag, "_op"},    32'(bus.cell_op),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       q_we   [3];
    logic [3:0] q_addr [3];
    logic [7:0] q_data [3];
    int         acc    [3];
    int         idx;
    logic       took;

    n_vec = 0;
    n_err = 0;
    clk_en = 1'b0;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 4'd0;
    bus.req_wdata = 8'h00;

    // Reset applied with no clock running.
    #3 rst = 1'b1;
    #2;
    check_idle_outputs("rst");
    check_vec("rst_rdata", 32'(bus.rsp_rdata),   32'd0);
    check_vec("rst_err",   32'(bus.rsp_err),     32'd0);
    check_vec("rst_in",    32'(bus.cell_in_bus), 32'd0);
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_idle_outputs("idle");
    end

    run_txn(1'b1, 4'd3, 8'h55, 8'h00, 1'b0);
    for (int k = 0; k < 8; k++) begin
      check_vec("mem_after_wr3", 32'(mem[k]), (k == 3) ? 32'h55 : 32'h00);
    end
    run_txn(1'b0, 4'd3, 8'h00, 8'h55, 1'b0);
    run_txn(1'b1, 4'd5, 8'h5A, 8'h00, 1'b0);
    run_txn(1'b1, 4'd3, 8'hCC, 8'h00, 1'b0);
    run_txn(1'b0, 4'd3, 8'h00, 8'hCC, 1'b0);
    run_txn(1'b0, 4'd5, 8'h00, 8'h5A, 1'b0);
    run_txn(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);

    // Out-of-range address: error response in cycle 1 and no cell access.
    run_txn(1'b1, 4'd9, 8'hFF, 8'h00, 1'b1);
    check_vec("err_mem1", 32'(mem[1]), 32'h00);

    // Continuous valid with three pending requests.
    q_we[0] = 1'b1; q_addr[0] = 4'd1; q_data[0] = 8'h11;
    q_we[1] = 1'b1; q_addr[1] = 4'd6; q_data[1] = 8'h66;
    q_we[2] = 1'b0; q_addr[2] = 4'd1; q_data[2] = 8'h00;
    idx = 0;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_we    = q_we[0];
    bus.req_addr  = q_addr[0];
    bus.req_wdata = q_data[0];
    for (int t = 0; t < 40 && idx < 3; t++) begin
      if (t > 0) @(negedge clk);
      took = bus.req_ready;
      if (took) acc[idx] = t;
      @(posedge clk);
      #1;
      if (took) begin
        idx++;
        if (idx < 3) begin
          bus.req_we    = q_we[idx];
          bus.req_addr  = q_addr[idx];
          bus.req_wdata = q_data[idx];
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    bus.req_valid = 1'b0;
    check_vec("q_count", 32'(idx), 32'd3);
    if (idx == 3) begin
      check_vec("q_gap01", 32'(acc[1] - acc[0]), 32'd6);
      check_vec("q_gap12", 32'(acc[2] - acc[1]), 32'd6);
    end
    repeat (6) @(negedge clk);
    check_vec("q_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check_vec("q_rsp_rdata", 32'(bus.rsp_rdata), 32'h11);
    check_vec("q_mem6",      32'(mem[6]),        32'h66);

    // Reset pulse while a write to word 2 holds its select.
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 4'd2;
    bus.req_wdata = 8'hA5;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_vec("rst_pre_sel", 32'(bus.cell_sel), 32'h04);
    #1 rst = 1'b1;
    #1;
    check_vec("rst_mid_sel",   32'(bus.cell_sel),  32'd0);
    check_vec("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    check_vec("rst_mid_rsp",   32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check_idle_outputs("post_rst");
    end
    run_txn(1'b0, 4'd5, 8'h00, 8'h5A, 1'b0);
    run_txn(1'b0, 4'd6, 8'h00, 8'h66, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
